serial_add_seq: RTL and testbench

Bit-serial N-bit adder sequencer that drives the team's 1-bit gate-level full-adder cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. Each clock it presents one operand bit pair plus the running carry to the external cell, then captures the cell's sum and carry-out. After WIDTH bit-cycles it returns the full sum and carry-out through a second valid/ready handshake. It sits directly upstream of the adder cell and also consumes the cell's outputs.

---
 rtl/serial_add_seq.sv | 104 ++++++++++
 tb/tb_serial_add_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder sequencer driving an external 1-bit full-adder cell.
// Operands are shifted out LSB first; the cell's sum bits are shifted back in from the top.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_sum,
  input  logic             fa_co,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_shift;

  // A 1-bit result has nothing to shift down; the new bit is the whole word.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = fa_sum;
    end else begin : g_wn
      assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_valid) begin
        state_d = RUN;
        a_d     = a_in;
        b_d     = b_in;
        carry_d = cin_in;
        cnt_d   = '0;
        sum_d   = '0;
      end
      RUN: begin
        sum_d   = sum_shift;
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE) && !rst;
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign fa_a        = (state_q == RUN) && a_q[0];
  assign fa_b        = (state_q == RUN) && b_q[0];
  assign fa_ci       = (state_q == RUN) && carry_q;
  assign res_sum     = sum_q;
  assign res_cout    = carry_q;

`ifndef SYNTHESIS
  a_cell_known: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN) |-> !$isunknown({fa_sum, fa_co}))
    else $error("serial_add_seq: adder cell output unknown during RUN");
`endif
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq at WIDTH=8 and WIDTH=1, each with a behavioural full-adder cell.
module tb_serial_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // WIDTH=8 instance
  logic       sv8 = 0, rr8 = 1, ci8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       sr8, fa_a8, fa_b8, fa_ci8, fs8, fc8, rv8, co8, busy8;
  logic [7:0] rs8;
  assign fs8 = fa_a8 ^ fa_b8 ^ fa_ci8;
  assign fc8 = (fa_a8 & fa_b8) | (fa_a8 & fa_ci8) | (fa_b8 & fa_ci8);

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .cin_in(ci8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8), .fa_sum(fs8), .fa_co(fc8),
    .res_valid(rv8), .res_ready(rr8), .res_sum(rs8), .res_cout(co8), .busy(busy8));

  // WIDTH=1 instance
  logic sv1 = 0, rr1 = 1, ci1 = 0;
  logic a1 = 0, b1 = 0;
  logic sr1, fa_a1, fa_b1, fa_ci1, fs1, fc1, rv1, co1, busy1;
  logic rs1;
  assign fs1 = fa_a1 ^ fa_b1 ^ fa_ci1;
  assign fc1 = (fa_a1 & fa_b1) | (fa_a1 & fa_ci1) | (fa_b1 & fa_ci1);

  serial_add_seq #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .cin_in(ci1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_ci(fa_ci1), .fa_sum(fs1), .fa_co(fc1),
    .res_valid(rv1), .res_ready(rr1), .res_sum(rs1), .res_cout(co1), .busy(busy1));

  // Reference: carry entering bit i is the overflow of the low i bits plus cin.
  function automatic int carry_into(input int a, input int b, input int ci, input int i);
    int m;
    m = (1 << i) - 1;
    return ((a & m) + (b & m) + ci) >> i;
  endfunction

  // One operation on the WIDTH=8 block; returns at the first negedge with res_valid high.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
    int exp, g, cyc;
    exp = int'(a) + int'(b) + int'(ci);
    g = 0;
    while (!sr8 && g < 40) begin @(negedge clk); g++; end
    chk({tag, "_rdy"}, 32'(sr8), 32'd1);
    a8 = a; b8 = b; ci8 = ci; sv8 = 1;
    @(negedge clk);
    sv8 = 0;
    cyc = 0;
    while (!rv8 && cyc < 40) begin
      if (cyc < 8) begin
        chk({tag, "_fa_a"},  32'(fa_a8),  32'(a[cyc]));
        chk({tag, "_fa_b"},  32'(fa_b8),  32'(b[cyc]));
        chk({tag, "_fa_ci"}, 32'(fa_ci8), 32'(carry_into(a, b, ci, cyc) & 1));
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"},  32'(cyc), 32'd8);
    chk({tag, "_sum"},  32'(rs8), 32'(exp & 8'hFF));
    chk({tag, "_cout"}, 32'(co8), 32'((exp >> 8) & 1));
  endtask

  initial begin
    int exp, cyc, last_acc, got_n, g;
    logic [7:0] hold_s;
    logic       hold_c;
    logic [16:0] q[$];
    logic [16:0] ent;

    // Reset state
    @(negedge clk);
    chk("rst_sr_held", 32'(sr8), 32'd0);
    chk("rst_rv", 32'(rv8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
    chk("rst_sum", 32'({co8, rs8}), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_sr", 32'(sr8), 32'd1);

    // Directed sums
    run_op8(8'h5A, 8'h33, 1'b0, "d5A33");
    chk("d5A33_exact", 32'({co8, rs8}), 32'h08D);
    @(negedge clk);
    run_op8(8'hFF, 8'h01, 1'b0, "dFF01");
    @(negedge clk);
    run_op8(8'hFF, 8'hFF, 1'b1, "dFFFF1");
    chk("dFFFF1_exact", 32'({co8, rs8}), 32'h1FF);
    @(negedge clk);

    // Backpressure in DONE, with an ignored start pulse
    rr8 = 0;
    run_op8(8'hC3, 8'h4E, 1'b1, "bp");
    hold_s = rs8; hold_c = co8;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a8 = 8'h01; b8 = 8'h02; ci8 = 1; sv8 = 1; end
      @(negedge clk);
      sv8 = 0;
      chk("bp_sum_hold", 32'(rs8), 32'(hold_s));
      chk("bp_cout_hold", 32'(co8), 32'(hold_c));
      chk("bp_rv", 32'(rv8), 32'd1);
      chk("bp_sr", 32'(sr8), 32'd0);
    end
    rr8 = 1;
    @(negedge clk);
    chk("bp_release_busy", 32'(busy8), 32'd0);
    run_op8(8'h81, 8'h7F, 1'b0, "bp_next");
    @(negedge clk);

    // Reset after bit 3 of an operation
    a8 = 8'hAA; b8 = 8'h55; ci8 = 0; sv8 = 1;
    @(negedge clk);
    sv8 = 0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy8), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_sr", 32'(sr8), 32'd0);
    rst = 0;
    chk("mid_rv", 32'(rv8), 32'd0);
    chk("mid_busy0", 32'(busy8), 32'd0);
    chk("mid_fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
    chk("mid_sum", 32'({co8, rs8}), 32'd0);
    run_op8(8'h10, 8'h20, 1'b0, "post_rst");
    chk("post_rst_exact", 32'({co8, rs8}), 32'h030);
    @(negedge clk);

    // Back-to-back with start_valid and res_ready tied high
    rr8 = 1; sv8 = 1;
    cyc = 0; last_acc = -1; got_n = 0;
    while (got_n < 100 && cyc < 2000) begin
      if (rv8) begin
        if (q.size() == 0) chk("b2b_unexpected", 32'd1, 32'd0);
        else begin
          ent = q.pop_front();
          exp = int'(ent[16:9]) + int'(ent[8:1]) + int'(ent[0]);
          chk("b2b_res", 32'({co8, rs8}), 32'(exp & 9'h1FF));
        end
        got_n++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      if (sr8) begin
        q.push_back({a8, b8, ci8});
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 32'(got_n), 32'd100);
    sv8 = 0;
    g = 0;
    while (busy8 && g < 40) begin @(negedge clk); g++; end
    chk("b2b_drain", 32'(busy8), 32'd0);

    // WIDTH=1 corner
    a1 = 1; b1 = 1; ci1 = 1; sv1 = 1;
    @(negedge clk);
    sv1 = 0;
    cyc = 0;
    while (!rv1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("w1_lat", 32'(cyc), 32'd1);
    chk("w1_sum", 32'(rs1), 32'd1);
    chk("w1_cout", 32'(co1), 32'd1);
    @(negedge clk);
    chk("w1_idle", 32'(sr1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
